fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Small in-order FIFO between the instruction cache and the decode stage.
- Captures each {pc, inst} pair the fetch side produces once the cache is not stalling, and presents it to decode with a valid/ready handshake.
- Decouples decode back-pressure from the fetch pipeline and absorbs short cache-hit bursts.
- Supports single-cycle flush on redirect (branch mispredict, trap, switch_mode).

Parameters:
- ADDR_WIDTH, 64, width of the pc carried with each instruction.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- if_valid  input  1  fetch side offers an instruction this cycle (driven as if_request && !if_stall).
- if_pc  input  ADDR_WIDTH  pc of the offered instruction.
- if_inst  input  32  offered instruction word.
- if_ready  output  1  buffer accepts an offer this cycle.
- flush  input  1  discard all entries and any same-cycle offer.
- id_valid  output  1  head entry valid for decode.
- id_pc  output  ADDR_WIDTH  pc of head entry.
- id_inst  output  32  instruction of head entry.
- id_misaligned  output  1  head entry pc[1:0] != 0.
- id_ready  input  1  decode consumes the head entry this cycle.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (rstn low, asynchronous)
  - head, tail and count clear to 0.
  - Storage clears to 0 and all misaligned flags clear.
  - Outputs during and after reset: if_ready=1, id_valid=0, id_pc=0, id_inst=32'h0000_0013, id_misaligned=0, count=0.
- Storage and pointers
  - Register array of DEPTH entries, each {pc, inst, misaligned}.
  - head and tail are $clog2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - count is tracked separately to distinguish full from empty.
- Push and pop
  - push = if_valid && if_ready && !flush.
    - Writes {if_pc, if_inst, if_pc[1:0]!=0} at tail, then tail increments.
  - pop = id_valid && id_ready && !flush.
    - head increments.
  - if_ready = (count < DEPTH). It is purely combinational from count.
    - When full, a push is refused even if a pop occurs in the same cycle; there is no full-throughput pass-through.
  - If push and pop occur together, count is unchanged and both pointers advance.
  - count next value = count + push - pop.
- Output side
  - id_valid = (count != 0).
  - id_pc, id_inst and id_misaligned read the entry at head combinationally.
  - When empty, the outputs are forced to pc 0, inst 32'h0000_0013 (NOP) and misaligned 0.
- Latency and ordering
  - No bypass: a pushed entry is visible on id_* at the earliest on the cycle after the push edge.
  - Latency from if_valid to id_valid is 1 cycle.
  - Entries leave in strict push order.
- Flush
  - Has priority over push and pop.
  - On the edge where flush=1: head=tail=count=0, the same-cycle offer is dropped, and no entry is consumed.
  - From the next cycle id_valid=0 and if_ready=1.
  - Storage contents need not be cleared.
  - Flush while empty is a no-op apart from resetting the pointers.
- Wrap-around
  - Pointers wrap from DEPTH-1 to 0 with no gap.
  - Occupancy is exact across wraps.
- The misaligned flag is carried only; the buffer takes no action on it.
- If rstn is asserted mid-operation, all state is lost immediately; no partial entry survives.

Test Plan:
- Reset then idle
  - Stimulus: hold rstn=0 for 3 cycles, release, drive if_valid=0.
  - Required: count=0, id_valid=0, id_inst=0x00000013, id_pc=0, if_ready=1 throughout.
- Single transfer latency
  - Stimulus: cycle 0 drive if_valid=1, if_pc=0x8000_0000, if_inst=0x0010_0093, with id_ready=1.
  - Required: cycle 1 shows id_valid=1, id_pc=0x8000_0000, id_inst=0x0010_0093.
  - Required: cycle 2 shows id_valid=0 and count=0.
- Fill to full with DEPTH=4, id_ready=0
  - Stimulus: push pcs 0x100, 0x104, 0x108, 0x10C, then offer 0x110.
  - Required: count=4, if_ready=0, 0x110 not accepted.
  - Stimulus: raise id_ready for 4 cycles.
  - Required: id_pc sequence is 0x100, 0x104, 0x108, 0x10C.
- Simultaneous push/pop and wrap
  - Stimulus: with count=2, push and pop every cycle for 10 cycles, pcs incrementing by 4.
  - Required: count stays 2, output order exact, and head/tail wrap past index 3 correctly.
- Flush priority
  - Stimulus: with count=3, assert flush together with if_valid=1 and id_ready=1.
  - Required: next cycle count=0, id_valid=0, if_ready=1.
  - Stimulus: a push on the following cycle.
  - Required: that entry appears as the sole entry.
- Misaligned flag and async reset mid-fill
  - Stimulus: push if_pc=0x202.
  - Required: id_misaligned=1 on its output cycle.
  - Stimulus: with count=2, drop rstn between clock edges.
  - Required: count=0 and id_valid=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/fetch_buffer.sv
// In-order {pc, inst} FIFO between the instruction cache and decode.
// Valid/ready on both sides, single-cycle flush on redirect, no bypass path.
module fetch_buffer #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic [31:0]           if_inst,
  output logic                  if_ready,

  input  logic                  flush,

  output logic                  id_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [31:0]           id_inst,
  output logic                  id_misaligned,
  input  logic                  id_ready,

  output logic [CNT_W-1:0]      count
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           inst;
    logic                  misaligned;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              pop;

  // Handshake qualifiers; flush overrides both sides of the buffer.
  assign if_ready = (count < CNT_W'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count_next;
    end
  end

  // NOTE: the storage array is reset here because its contents must read as zero after reset;
  // flush leaves it untouched since the pointers alone make old entries unreachable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[tail] <= '{pc: if_pc, inst: if_inst, misaligned: (if_pc[1:0] != 2'b00)};
    end
  end

  // Empty buffer presents a NOP at pc 0 so decode never sees stale data.
  always_comb begin
    id_pc         = '0;
    id_inst       = NOP_INST;
    id_misaligned = 1'b0;
    if (id_valid) begin
      id_pc         = mem[head].pc;
      id_inst       = mem[head].inst;
      id_misaligned = mem[head].misaligned;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: stimulus queues expected entries, a negedge
// monitor pops and compares each one decode consumes.
module tb_fetch_buffer;

  localparam int ADDR_WIDTH = 64;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  rstn;
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [31:0]           if_inst;
  logic                  if_ready;
  logic                  flush;
  logic                  id_valid;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [31:0]           id_inst;
  logic                  id_misaligned;
  logic                  id_ready;
  logic [CNT_W-1:0]      count;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  fetch_buffer #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_ready      (if_ready),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_misaligned (id_misaligned),
    .id_ready      (id_ready),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [63:0] pc);
    return {pc[15:0], 16'h0113};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] inst);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  task automatic sb_push(input logic [63:0] pc, input logic [31:0] inst, input logic mis);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    e.mis  = mis;
    sb.push_back(e);
  endtask

  // Monitor: a consume happens on the coming edge whenever valid && ready && !flush.
  always @(negedge clk) begin
    if (rstn && id_valid && id_ready && !flush) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_output actual_pc=%0h required=no_entry", id_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("id_pc",         id_pc,                e.pc);
        check("id_inst",       64'(id_inst),         64'(e.inst));
        check("id_misaligned", 64'(id_misaligned),   64'(e.mis));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_valid = 1'b0;
    if_pc    = '0;
    if_inst  = '0;
    flush    = 1'b0;
    id_ready = 1'b0;
    rstn     = 1'b1;
    #1 rstn  = 1'b0;

    // Reset then idle
    @(negedge clk);
    check("rst_count",    64'(count),    64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_id_pc",    id_pc,         64'd0);
    check("rst_id_inst",  64'(id_inst),  64'h13);
    check("rst_if_ready", 64'(if_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_count",    64'(count),    64'd0);
      check("idle_id_valid", 64'(id_valid), 64'd0);
      check("idle_id_inst",  64'(id_inst),  64'h13);
      check("idle_if_ready", 64'(if_ready), 64'd1);
    end

    // Single transfer latency
    step();
    id_ready = 1'b1;
    offer(64'h8000_0000, 32'h0010_0093);
    sb_push(64'h8000_0000, 32'h0010_0093, 1'b0);
    @(negedge clk);
    check("lat_no_bypass", 64'(id_valid), 64'd0);
    step();
    if_valid = 1'b0;
    @(negedge clk);
    check("lat_id_valid", 64'(id_valid), 64'd1);
    step();
    @(negedge clk);
    check("lat_drained_valid", 64'(id_valid), 64'd0);
    check("lat_drained_count", 64'(count),    64'd0);

    // Fill to full, then refuse an offer both with and without a same-cycle pop
    step();
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(64'h100 + 64'(4 * i), mk_inst(64'h100 + 64'(4 * i)));
      sb_push(64'h100 + 64'(4 * i), mk_inst(64'h100 + 64'(4 * i)), 1'b0);
      step();
    end
    offer(64'h110, mk_inst(64'h110));
    @(negedge clk);
    check("full_count",    64'(count),    64'd4);
    check("full_if_ready", 64'(if_ready), 64'd0);
    step();
    id_ready = 1'b1;
    @(negedge clk);
    check("full_count_held",   64'(count),    64'd4);
    check("full_ready_on_pop", 64'(if_ready), 64'd0);
    step();
    if_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("drain_count",    64'(count),    64'd0);
    check("drain_id_valid", 64'(id_valid), 64'd0);

    // Simultaneous push/pop with pointer wrap
    step();
    id_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      offer(64'h300 + 64'(4 * i), mk_inst(64'h300 + 64'(4 * i)));
      sb_push(64'h300 + 64'(4 * i), mk_inst(64'h300 + 64'(4 * i)), 1'b0);
      step();
    end
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(64'h308 + 64'(4 * i), mk_inst(64'h308 + 64'(4 * i)));
      sb_push(64'h308 + 64'(4 * i), mk_inst(64'h308 + 64'(4 * i)), 1'b0);
      @(negedge clk);
      check("pp_count", 64'(count), 64'd2);
      step();
    end
    if_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("pp_drain_count", 64'(count), 64'd0);

    // Flush priority over push and pop
    step();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(64'h400 + 64'(4 * i), mk_inst(64'h400 + 64'(4 * i)));
      sb_push(64'h400 + 64'(4 * i), mk_inst(64'h400 + 64'(4 * i)), 1'b0);
      step();
    end
    flush    = 1'b1;
    id_ready = 1'b1;
    offer(64'h40C, mk_inst(64'h40C));
    sb.delete();
    @(negedge clk);
    check("pre_flush_count", 64'(count), 64'd3);
    step();
    flush    = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b0;
    @(negedge clk);
    check("flush_count",    64'(count),    64'd0);
    check("flush_id_valid", 64'(id_valid), 64'd0);
    check("flush_if_ready", 64'(if_ready), 64'd1);
    step();
    offer(64'h500, mk_inst(64'h500));
    sb_push(64'h500, mk_inst(64'h500), 1'b0);
    step();
    if_valid = 1'b0;
    @(negedge clk);
    check("post_flush_count", 64'(count), 64'd1);
    check("post_flush_pc",    id_pc,      64'h500);
    step();
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    @(negedge clk);
    check("post_flush_drain", 64'(count), 64'd0);

    // Misaligned flag carried through
    step();
    id_ready = 1'b1;
    offer(64'h202, mk_inst(64'h202));
    sb_push(64'h202, mk_inst(64'h202), 1'b1);
    step();
    if_valid = 1'b0;
    @(negedge clk);
    check("mis_flag", 64'(id_misaligned), 64'd1);

    // Asynchronous reset mid-fill
    step();
    id_ready = 1'b0;
    offer(64'h600, mk_inst(64'h600));
    sb_push(64'h600, mk_inst(64'h600), 1'b0);
    step();
    offer(64'h604, mk_inst(64'h604));
    sb_push(64'h604, mk_inst(64'h604), 1'b0);
    step();
    if_valid = 1'b0;
    @(negedge clk);
    check("pre_arst_count", 64'(count), 64'd2);
    #2 rstn = 1'b0;
    sb.delete();
    #1;
    check("arst_count",    64'(count),    64'd0);
    check("arst_id_valid", 64'(id_valid), 64'd0);
    check("arst_if_ready", 64'(if_ready), 64'd1);
    check("arst_id_inst",  64'(id_inst),  64'h13);
    check("arst_id_pc",    id_pc,         64'd0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    check("post_arst_count", 64'(count), 64'd0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
